mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BUS_WIDTH, default 32, SHALL set data and address width.
REQ-002 Parameter WAIT_CYCLES, default 1, SHALL set memory access cycles; legal range 1..15; out of range SHALL raise an elaboration $error.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 m0_req / m1_req  input  1  access request: m0 is the core, m1 is the loader/debug port.
REQ-006 m0_we / m1_we  input  1  1 = write, 0 = read; valid while the matching req is high.
REQ-007 m0_addr / m1_addr  input  BUS_WIDTH  access address.
REQ-008 m0_wdata / m1_wdata  input  BUS_WIDTH  write data.
REQ-009 m0_gnt / m1_gnt  output  1  one-cycle grant pulse.
REQ-010 m0_done / m1_done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  BUS_WIDTH  read data, shared, valid in the done cycle.
REQ-012 mem_we  output  1  memory write strobe.
REQ-013 mem_addr, mem_wdata  output  BUS_WIDTH  memory address and write data.
REQ-014 mem_rdata  input  BUS_WIDTH  memory read data.

Function
REQ-015 The FSM SHALL have states IDLE, BUSY and DONE; any unreachable encoding SHALL return to IDLE.
REQ-016 In IDLE, if any req is high at edge T: the FSM SHALL latch the winner's id, we, addr and wdata, load the wait counter with WAIT_CYCLES, and enter BUSY.
REQ-017 The winner's gnt SHALL be high only in cycle T+1, which is the first BUSY cycle.
REQ-018 In BUSY, mem_addr and mem_wdata SHALL come from the latched registers, held stable for the whole transaction.
REQ-019 mem_we SHALL be high only in the first BUSY cycle, and only for a write.
REQ-020 The counter SHALL decrement once per BUSY cycle; when it equals 1, the FSM SHALL register mem_rdata into rdata and enter DONE.
REQ-021 A write transaction SHALL leave rdata unchanged.
REQ-022 In DONE, the owner's done SHALL pulse for exactly one cycle, and the FSM SHALL then enter IDLE unconditionally.
REQ-023 End-to-end latency SHALL be fixed: done arrives in cycle T+WAIT_CYCLES+1. Minimum spacing between grants SHALL be WAIT_CYCLES+2 cycles.
REQ-024 The requester SHALL hold req, we, addr and wdata until gnt.
REQ-025 A req dropped before it is sampled SHALL be ignored.
REQ-026 Inputs SHALL be ignored in BUSY and DONE.
REQ-027 A req still high in IDLE after done SHALL start a new transaction.
REQ-028 The non-owner's gnt and done SHALL stay 0 throughout.

Reset
REQ-029 While rst is sampled high, the FSM SHALL go to IDLE.
REQ-030 On reset, the counter, latched registers, rdata, mem_addr, mem_wdata, mem_we, gnt and done SHALL all be 0, and last-owner SHALL be m1.
REQ-031 Reset in BUSY or DONE SHALL abort the transaction: no done pulse, and mem_we SHALL be 0 from the next cycle.

Configuration
REQ-032 Macro MEM_ARB_RR_EN defined: round-robin arbitration; on simultaneous requests, the grant SHALL go to the requester other than last-owner.
REQ-033 last-owner SHALL update on each grant.
REQ-034 Macro MEM_ARB_RR_EN undefined: fixed priority, m0 SHALL always win; the last-owner register SHALL not be built.
REQ-035 With a single requester, both modes SHALL behave identically.

Structure
REQ-036 Package mem_arb_pkg SHALL hold: the state enum typedef; the requester-id typedef (M0, M1); counter width constant 4; and the WAIT_CYCLES range limits.
REQ-037 Combinational winner selection SHALL be in one sub-module, mem_arb_picker.
REQ-038 mem_arb_picker SHALL take the two reqs and last-owner and output the winner id and a valid flag.

Verification (WAIT_CYCLES=2 unless stated)
REQ-039 m0 read, addr 0x10, mem_rdata 0xDEADBEEF, req at T: m0_gnt at T+1, mem_we=0, m0_done at T+3, rdata 0xDEADBEEF.
REQ-040 m1 write, addr 0x20, wdata 0x12345678: mem_we high one cycle with mem_addr 0x20; mem_wdata 0x12345678 held 2 cycles; m1_done at T+3; rdata unchanged.
REQ-041 Both req held high for 4 transactions, fixed priority: 4 m0 grants, no m1 grant. With MEM_ARB_RR_EN: grant order m0, m1, m0, m1.
REQ-042 rst asserted in the 2nd BUSY cycle of an m0 read: next cycle IDLE, all outputs 0, no m0_done.
REQ-043 WAIT_CYCLES=15, m0 read: m0_done exactly 16 cycles after the req edge; next grant no earlier than 17 cycles after the first.
REQ-044 m0_req pulsed in BUSY of an m1 transaction, low again before DONE: no m0 grant.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the two-master memory arbiter.
package mem_arb_pkg;

  localparam int CNT_W    = 4;
  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } id_t;

  function automatic id_t other_id(id_t id);
    return (id == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection between the core (m0) and the loader/debug port (m1).
// MEM_ARB_RR_EN selects round-robin on collisions; otherwise m0 always wins.
module mem_arb_picker
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  id_t  last_owner,
  output id_t  winner,
  output logic valid
);

  always_comb begin
    valid  = req0 | req1;
    winner = M0;
`ifdef MEM_ARB_RR_EN
    if (req0 && req1) begin
      winner = other_id(last_owner);
    end else if (req1) begin
      winner = M1;
    end
`else
    if (!req0 && req1) begin
      winner = M1;
    end
`endif
  end

`ifndef MEM_ARB_RR_EN
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: one transaction at a time, fixed WAIT_CYCLES memory latency.
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; default is fixed m0 priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BUS_WIDTH   = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [BUS_WIDTH-1:0] m0_addr,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [BUS_WIDTH-1:0] m1_addr,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  output logic                 m0_gnt,
  output logic                 m1_gnt,
  output logic                 m0_done,
  output logic                 m1_done,
  output logic [BUS_WIDTH-1:0] rdata,
  output logic                 mem_we,
  output logic [BUS_WIDTH-1:0] mem_addr,
  output logic [BUS_WIDTH-1:0] mem_wdata,
  input  logic [BUS_WIDTH-1:0] mem_rdata
);

  if (WAIT_CYCLES < WAIT_MIN || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("mem_arbiter: WAIT_CYCLES=%0d outside %0d..%0d", WAIT_CYCLES, WAIT_MIN, WAIT_MAX);
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  id_t              owner;
  logic             owner_we;
  logic [CNT_W-1:0] cnt;

  id_t                  win_id;
  logic                 win_vld;
  id_t                  pick_last;
  logic                 sel_we;
  logic [BUS_WIDTH-1:0] sel_addr;
  logic [BUS_WIDTH-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
  id_t last_owner;
  assign pick_last = last_owner;
`else
  assign pick_last = M1;
`endif

  mem_arb_picker u_picker (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (pick_last),
    .winner     (win_id),
    .valid      (win_vld)
  );

  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (win_id == M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // mem_addr/mem_wdata double as the latched request; they hold until the next grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= M0;
      owner_we  <= 1'b0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      rdata     <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_owner <= M1;
`endif
    end else begin
      m0_gnt  <= 1'b0;
      m1_gnt  <= 1'b0;
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner     <= win_id;
            owner_we  <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_we    <= sel_we;
            cnt       <= CNT_LOAD;
            m0_gnt    <= (win_id == M0);
            m1_gnt    <= (win_id == M1);
`ifdef MEM_ARB_RR_EN
            last_owner <= win_id;
`endif
            state     <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (!owner_we) begin
              rdata <= mem_rdata;
            end
            m0_done <= (owner == M0);
            m1_done <= (owner == M1);
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(m0_gnt && m1_gnt));
  a_done_onehot: assert property (@(posedge clk) disable iff (rst) !(m0_done && m1_done));
  a_we_first_busy: assert property (@(posedge clk) disable iff (rst) mem_we |-> (m0_gnt || m1_gnt));
  a_done_state: assert property (@(posedge clk) disable iff (rst) (m0_done || m1_done) |-> (state == DONE));
  a_busy_cnt: assert property (@(posedge clk) disable iff (rst) (state == BUSY) |-> (cnt != '0));

endmodule
